// File: rtl/pipe_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pipe_ctrl_pkg
// Shared definitions for the pipeline hazard controller and the stage
// registers it drives:
//   - hz_state_e : controller FSM states (RUN / MEM_WAIT / MDU_WAIT)
//   - RA_W_DEF   : default register-address width
//   - CTL_*      : bit positions inside the packed per-stage control vector
// -----------------------------------------------------------------------------
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    MDU_WAIT = 2'd2
  } hz_state_e;

  localparam int RA_W_DEF = 5;

  // Control-vector field positions. The stage registers decode the same
  // vector, so these positions must stay in step with them.
  localparam int CTL_PC_WRITE     = 0;
  localparam int CTL_IFID_WRITE   = 1;
  localparam int CTL_IF_FLUSH     = 2;
  localparam int CTL_IDEX_BUBBLE  = 3;
  localparam int CTL_IDEX_WRITE   = 4;
  localparam int CTL_EXMEM_WRITE  = 5;
  localparam int CTL_MEMWB_BUBBLE = 6;
  localparam int CTL_MDU_START    = 7;
  localparam int CTL_W            = 8;

endpackage

// File: rtl/hazard_perf_cnt.sv
// -----------------------------------------------------------------------------
// hazard_perf_cnt
// Saturating event counter used for the hazard controller's performance
// statistics. Only built when HAZARD_PERF_CNT_EN is defined; without the
// macro this file contributes no module, so nothing stray is elaborated.
// Ports:
//   clk   in  1  clock, rising edge
//   rst   in  1  asynchronous, active-high reset (count returns to 0)
//   inc   in  1  count this cycle
//   count out W  current count, holds at all-ones
// -----------------------------------------------------------------------------
`ifdef HAZARD_PERF_CNT_EN
module hazard_perf_cnt #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg <= '0;
    end else if (inc && (count_reg != '1)) begin
      count_reg <= count_reg + W'(1);
    end
  end

  assign count = count_reg;

endmodule
`endif

// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
// Central stall/flush controller for the 5-stage pipeline. Resolves slow
// memory freezes, multi-cycle MDU occupancy, load-use hazards and taken
// branch flushes into one prioritised set of per-stage controls
// (memory freeze > MDU stall > load-use stall > branch flush).
// All outputs are Mealy: combinational from state, mdu_cnt and inputs.
//
// Optional feature: define HAZARD_PERF_CNT_EN to build the stall-cycle and
// flush counters; otherwise stall_cycles_o / flush_count_o are tied to 0.
//
// Ports:
//   clk_i, rst_i            clock, asynchronous active-high reset
//   id_rs_i, id_rt_i        source registers of the ID instruction
//   id_uses_rt_i            ID instruction reads rt
//   id_mdu_op_i             ID instruction is a mul/div
//   id_branch_taken_i       branch resolved taken in ID
//   ex_memread_i, ex_rt_i   EX instruction is a load, and its destination
//   mem_req_i, mem_ack_i    slow-memory access in MEM and its completion
//   pc_write_o .. mdu_start_o  per-stage write enables / bubbles / flush
//   stall_cycles_o, flush_count_o  performance counters (optional)
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MDU_LAT = 4,          // 1..15
  parameter int RA_W    = RA_W_DEF,
  parameter int PERF_W  = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [RA_W-1:0]   id_rs_i,
  input  logic [RA_W-1:0]   id_rt_i,
  input  logic              id_uses_rt_i,
  input  logic              id_mdu_op_i,
  input  logic              id_branch_taken_i,
  input  logic              ex_memread_i,
  input  logic [RA_W-1:0]   ex_rt_i,
  input  logic              mem_req_i,
  input  logic              mem_ack_i,
  output logic              pc_write_o,
  output logic              ifid_write_o,
  output logic              if_flush_o,
  output logic              idex_bubble_o,
  output logic              idex_write_o,
  output logic              exmem_write_o,
  output logic              memwb_bubble_o,
  output logic              mdu_start_o,
  output logic [PERF_W-1:0] stall_cycles_o,
  output logic [PERF_W-1:0] flush_count_o
);

  hz_state_e        state_reg, state_next;
  logic [3:0]       mdu_cnt_reg, mdu_cnt_next;
  logic             freeze, mdu_busy, load_use, mdu_issue;
  logic [CTL_W-1:0] ctl;

  assign freeze   = mem_req_i && !mem_ack_i;
  assign mdu_busy = (mdu_cnt_reg != 4'd0);

  // Register 0 is hard-wired, so a load "to" r0 never creates a hazard.
  assign load_use = ex_memread_i && (ex_rt_i != '0) &&
                    ((ex_rt_i == id_rs_i) || (id_uses_rt_i && (ex_rt_i == id_rt_i)));

  // An MDU op only issues from RUN; the MEM_WAIT exit cycle defers it by one
  // cycle so the op is re-evaluated once the pipeline is running again.
  assign mdu_issue = id_mdu_op_i && (state_reg == RUN) && !freeze && !load_use && !mdu_busy;

  // Per-stage control vector, highest-priority condition first.
  always_comb begin
    ctl = '0;
    if (rst_i) begin
      ctl[CTL_IDEX_BUBBLE]  = 1'b1;
      ctl[CTL_MEMWB_BUBBLE] = 1'b1;
    end else if (freeze) begin
      // Whole pipe holds; MEM/WB gets a bubble so WB does not repeat.
      ctl[CTL_MEMWB_BUBBLE] = 1'b1;
    end else if (mdu_busy || load_use) begin
      // Front end holds, a bubble enters EX, the back end drains.
      ctl[CTL_IDEX_BUBBLE]  = 1'b1;
      ctl[CTL_IDEX_WRITE]   = 1'b1;
      ctl[CTL_EXMEM_WRITE]  = 1'b1;
    end else begin
      ctl[CTL_PC_WRITE]     = 1'b1;
      ctl[CTL_IFID_WRITE]   = 1'b1;
      ctl[CTL_IDEX_WRITE]   = 1'b1;
      ctl[CTL_EXMEM_WRITE]  = 1'b1;
      ctl[CTL_IF_FLUSH]     = id_branch_taken_i;
      ctl[CTL_MDU_START]    = mdu_issue;
    end
  end

  assign pc_write_o     = ctl[CTL_PC_WRITE];
  assign ifid_write_o   = ctl[CTL_IFID_WRITE];
  assign if_flush_o     = ctl[CTL_IF_FLUSH];
  assign idex_bubble_o  = ctl[CTL_IDEX_BUBBLE];
  assign idex_write_o   = ctl[CTL_IDEX_WRITE];
  assign exmem_write_o  = ctl[CTL_EXMEM_WRITE];
  assign memwb_bubble_o = ctl[CTL_MEMWB_BUBBLE];
  assign mdu_start_o    = ctl[CTL_MDU_START];

  // mdu_cnt tracks real MDU occupancy, so it keeps counting through freezes.
  always_comb begin
    mdu_cnt_next = mdu_cnt_reg;
    if (mdu_issue) begin
      mdu_cnt_next = 4'(MDU_LAT - 1);
    end else if (mdu_busy) begin
      mdu_cnt_next = mdu_cnt_reg - 4'd1;
    end
  end

  always_comb begin
    state_next = state_reg;
    if (freeze) begin
      state_next = MEM_WAIT;
    end else begin
      case (state_reg)
        RUN: begin
          if (mdu_issue && (MDU_LAT > 1)) begin
            state_next = MDU_WAIT;
          end
        end
        // Ack cycle: resume MDU waiting only if the op outlives this cycle.
        MEM_WAIT: state_next = (mdu_cnt_reg > 4'd1) ? MDU_WAIT : RUN;
        MDU_WAIT: begin
          if (mdu_cnt_reg <= 4'd1) begin
            state_next = RUN;
          end
        end
        default:  state_next = RUN;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg   <= RUN;
      mdu_cnt_reg <= 4'd0;
    end else begin
      state_reg   <= state_next;
      mdu_cnt_reg <= mdu_cnt_next;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  hazard_perf_cnt #(.W(PERF_W)) u_stall_cnt (
    .clk   (clk_i),
    .rst   (rst_i),
    .inc   (!ctl[CTL_PC_WRITE] && !rst_i),
    .count (stall_cycles_o)
  );

  hazard_perf_cnt #(.W(PERF_W)) u_flush_cnt (
    .clk   (clk_i),
    .rst   (rst_i),
    .inc   (ctl[CTL_IF_FLUSH]),
    .count (flush_count_o)
  );
`else
  assign stall_cycles_o = '0;
  assign flush_count_o  = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
// Directed steps followed by a randomized run for pipe_hazard_ctrl. The
// reference model reasons in absolute cycle numbers: an MDU op issued in
// cycle t occupies EX until cycle t+MDU_LAT, and a cycle that follows a
// freeze is the memory-wait exit cycle. Counter expectations follow the
// HAZARD_PERF_CNT_EN build setting.
// -----------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

  localparam int MDU_LAT = 4;
  localparam int RA_W    = 5;
  localparam int PERF_W  = 32;
`ifdef HAZARD_PERF_CNT_EN
  localparam bit PERF_ON = 1'b1;
`else
  localparam bit PERF_ON = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [RA_W-1:0]   id_rs = '0, id_rt = '0, ex_rt = '0;
  logic              id_uses_rt = 1'b0, id_mdu_op = 1'b0, id_branch_taken = 1'b0;
  logic              ex_memread = 1'b0, mem_req = 1'b0, mem_ack = 1'b0;
  logic              pc_write, ifid_write, if_flush, idex_bubble;
  logic              idex_write, exmem_write, memwb_bubble, mdu_start;
  logic [PERF_W-1:0] stall_cycles, flush_count;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.MDU_LAT(MDU_LAT), .RA_W(RA_W), .PERF_W(PERF_W)) dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .id_rs_i           (id_rs),
    .id_rt_i           (id_rt),
    .id_uses_rt_i      (id_uses_rt),
    .id_mdu_op_i       (id_mdu_op),
    .id_branch_taken_i (id_branch_taken),
    .ex_memread_i      (ex_memread),
    .ex_rt_i           (ex_rt),
    .mem_req_i         (mem_req),
    .mem_ack_i         (mem_ack),
    .pc_write_o        (pc_write),
    .ifid_write_o      (ifid_write),
    .if_flush_o        (if_flush),
    .idex_bubble_o     (idex_bubble),
    .idex_write_o      (idex_write),
    .exmem_write_o     (exmem_write),
    .memwb_bubble_o    (memwb_bubble),
    .mdu_start_o       (mdu_start),
    .stall_cycles_o    (stall_cycles),
    .flush_count_o     (flush_count)
  );

  int checks = 0;
  int errors = 0;

  // Reference-model state
  int                cyc = 0;
  int                mdu_done = 0;
  bit                prev_frozen = 1'b0;
  logic [PERF_W-1:0] stall_model = '0;
  logic [PERF_W-1:0] flush_model = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: inputs were set by the caller just after a falling edge.
  // Outputs are checked 1 time unit later, then the model advances and the
  // task returns at the next falling edge.
  task automatic step(input string tag);
    logic [7:0] exp_v, obs_v;
    bit         frz, busy, lu, issue;
    #1;
    if (rst) begin
      mdu_done    = 0;
      prev_frozen = 1'b0;
      stall_model = '0;
      flush_model = '0;
    end
    frz   = mem_req && !mem_ack;
    busy  = (cyc < mdu_done);
    lu    = ex_memread && (ex_rt != 0) &&
            ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
    issue = 1'b0;
    // Vector order: pc, ifid, flush, idex_bubble, idex_write, exmem, memwb_bubble, start
    if (rst)              exp_v = 8'b0001_0010;
    else if (frz)         exp_v = 8'b0000_0010;
    else if (busy || lu)  exp_v = 8'b0001_1100;
    else begin
      issue = id_mdu_op && !prev_frozen;
      exp_v = {1'b1, 1'b1, id_branch_taken, 1'b0, 1'b1, 1'b1, 1'b0, issue};
    end
    obs_v = {pc_write, ifid_write, if_flush, idex_bubble,
             idex_write, exmem_write, memwb_bubble, mdu_start};
    check(tag, 64'(obs_v), 64'(exp_v));
    check({tag, "_stall_cnt"}, 64'(stall_cycles), PERF_ON ? 64'(stall_model) : 64'd0);
    check({tag, "_flush_cnt"}, 64'(flush_count), PERF_ON ? 64'(flush_model) : 64'd0);
    if (!rst) begin
      if (issue) mdu_done = cyc + MDU_LAT;
      prev_frozen = frz;
      if (!exp_v[7] && (stall_model != '1)) stall_model++;
      if (exp_v[5] && (flush_model != '1))  flush_model++;
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    id_rs = '0; id_rt = '0; ex_rt = '0;
    id_uses_rt = 1'b0; id_mdu_op = 1'b0; id_branch_taken = 1'b0;
    ex_memread = 1'b0; mem_req = 1'b0; mem_ack = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    // Reset, then load-use hazard visible right after release
    ex_memread = 1'b1; ex_rt = 5'd5; id_rs = 5'd5;
    step("reset_a");
    step("reset_b");
    rst = 1'b0;
    step("lu_after_reset");
    ex_memread = 1'b0;
    step("lu_cleared");

    // r0 never hazards
    ex_memread = 1'b1; ex_rt = 5'd0; id_rs = 5'd0;
    step("r0_no_hazard");

    // Branch alone, then branch against a load-use hit on rt
    ex_memread = 1'b0; id_branch_taken = 1'b1;
    step("branch_alone");
    ex_memread = 1'b1; ex_rt = 5'd7; id_rt = 5'd7; id_uses_rt = 1'b1; id_rs = 5'd3;
    step("branch_vs_lu");
    id_uses_rt = 1'b0;
    step("rt_unused_branch");
    idle_inputs();

    // MDU op: start pulse, three stall cycles, then running again.
    // Another MDU op held in ID must not issue while busy.
    id_mdu_op = 1'b1;
    step("mdu_issue");
    repeat (3) step("mdu_wait");
    id_mdu_op = 1'b0;
    step("mdu_done");

    // MDU op issued one cycle before a 3-cycle freeze expires during it
    id_mdu_op = 1'b1;
    step("mdu_pre_freeze");
    id_mdu_op = 1'b0; mem_req = 1'b1; mem_ack = 1'b0;
    repeat (3) step("mem_freeze");
    mem_ack = 1'b1;
    step("mem_ack");
    mem_req = 1'b0; mem_ack = 1'b0; id_mdu_op = 1'b1;
    step("run_after_ack");
    id_mdu_op = 1'b0;
    repeat (4) step("mdu_drain");

    // Counter scenario: 1 load-use, 3-cycle freeze, 2 flushes
    rst = 1'b1;
    step("perf_reset");
    rst = 1'b0;
    ex_memread = 1'b1; ex_rt = 5'd9; id_rs = 5'd9;
    step("perf_lu");
    ex_memread = 1'b0; mem_req = 1'b1;
    repeat (3) step("perf_freeze");
    mem_ack = 1'b1;
    step("perf_ack");
    mem_req = 1'b0; mem_ack = 1'b0; id_branch_taken = 1'b1;
    repeat (2) step("perf_flush");
    id_branch_taken = 1'b0;
    check("perf_stall_total", 64'(stall_cycles), PERF_ON ? 64'd4 : 64'd0);
    check("perf_flush_total", 64'(flush_count), PERF_ON ? 64'd2 : 64'd0);

    // Reset asserted mid-freeze with the MDU busy; RUN afterwards
    id_mdu_op = 1'b1;
    step("mdu_before_rst");
    id_mdu_op = 1'b0; mem_req = 1'b1;
    step("freeze_before_rst");
    rst = 1'b1;
    step("rst_mid_freeze");
    rst = 1'b0; mem_req = 1'b0; id_mdu_op = 1'b1;
    step("issue_after_rst");
    idle_inputs();
    repeat (3) step("drain_after_rst");

    // Randomized traffic; small register range to provoke hazards
    for (int i = 0; i < 600; i++) begin
      rst             = ($urandom_range(0, 79) == 0);
      id_rs           = RA_W'($urandom_range(0, 3));
      id_rt           = RA_W'($urandom_range(0, 3));
      ex_rt           = RA_W'($urandom_range(0, 3));
      id_uses_rt      = 1'($urandom);
      ex_memread      = ($urandom_range(0, 3) == 0);
      id_branch_taken = ($urandom_range(0, 3) == 0);
      id_mdu_op       = ($urandom_range(0, 4) == 0);
      mem_req         = mem_req ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 5) == 0);
      mem_ack         = mem_req && ($urandom_range(0, 2) == 0);
      step("random");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central stall/flush controller for the 5-stage pipeline. It drives the IF/ID register's write-enable and flush inputs, plus PC write, the ID/EX bubble and the EX/MEM freeze. It resolves load-use hazards, taken-branch flushes, multi-cycle MDU occupancy and slow-memory handshakes into one prioritised set of per-stage controls.

Parameters:
- MDU_LAT, 4, total EX-occupancy cycles of a mul/div op; legal range 1..15.
- RA_W, 5, register-address width.
- PERF_W, 32, width of the performance counters (optional feature only).

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- id_rs_i  in  RA_W  rs of the instruction in ID.
- id_rt_i  in  RA_W  rt of the instruction in ID.
- id_uses_rt_i  in  1  ID instruction reads rt.
- id_mdu_op_i  in  1  ID instruction is a mul/div.
- id_branch_taken_i  in  1  branch resolved taken in ID.
- ex_memread_i  in  1  EX instruction is a load.
- ex_rt_i  in  RA_W  load destination in EX.
- mem_req_i  in  1  MEM stage is accessing slow memory.
- mem_ack_i  in  1  slow memory completes this cycle.
- pc_write_o  out  1  PC update enable.
- ifid_write_o  out  1  IF/ID write-enable.
- if_flush_o  out  1  IF/ID flush (zeroes the pc4/instr fields).
- idex_bubble_o  out  1  zero the control bits entering ID/EX.
- idex_write_o  out  1  ID/EX write-enable.
- exmem_write_o  out  1  EX/MEM write-enable.
- memwb_bubble_o  out  1  zero the control bits entering MEM/WB.
- mdu_start_o  out  1  one-cycle start pulse to the MDU.
- stall_cycles_o  out  PERF_W  stall-cycle count (optional feature).
- flush_count_o  out  PERF_W  flush count (optional feature).

Behaviour:
- States: RUN, MEM_WAIT, MDU_WAIT. State register and the 4-bit mdu_cnt are reset asynchronously: state=RUN, mdu_cnt=0.
- Outputs are Mealy (combinational from state, mdu_cnt and inputs); zero-cycle latency to the stage registers.
- While rst_i is high: pc_write/ifid_write/idex_write/exmem_write=0, if_flush=0, idex_bubble=1, memwb_bubble=1, mdu_start=0.
- Priority (highest first): memory freeze > MDU stall > load-use stall > branch flush.
- Memory freeze: condition is mem_req_i && !mem_ack_i, in any state.
  - pc/ifid/idex/exmem writes=0, memwb_bubble=1; all other outputs 0.
  - Next state is MEM_WAIT.
  - If mem_req_i && mem_ack_i in the same cycle, there is no freeze.
- Leaving MEM_WAIT: on the cycle mem_ack_i=1 the pipeline advances. Next state is MDU_WAIT if mdu_cnt>1, else RUN.
- mdu_cnt is independent of the memory freeze:
  - Decrements every cycle while nonzero, including during a freeze.
  - Loaded with MDU_LAT-1 when an MDU op issues.
- MDU issue: id_mdu_op_i in RUN with no freeze and no load-use stall.
  - mdu_start_o=1 for exactly that cycle.
  - If MDU_LAT>1, next state is MDU_WAIT.
  - If MDU_LAT=1, no wait state is entered.
- MDU_WAIT (mdu_cnt!=0): pc_write=0, ifid_write=0, idex_bubble=1; exmem/memwb advance normally.
  - Returns to RUN in the cycle mdu_cnt reaches 1→0.
  - A new id_mdu_op_i is not issued while mdu_cnt!=0.
- Load-use stall: condition is ex_memread_i && ex_rt_i!=0 && (ex_rt_i==id_rs_i || (id_uses_rt_i && ex_rt_i==id_rt_i)).
  - pc_write=0, ifid_write=0, idex_bubble=1 for one cycle. State is unchanged.
- Branch flush: id_branch_taken_i with no higher-priority condition active.
  - pc_write=1, ifid_write=1, if_flush=1.
  - id_branch_taken_i is ignored during any stall or freeze; it is re-evaluated once the stall clears.
- Default (no condition active): all writes=1, bubbles=0, flush=0.
- Register 0 never causes a hazard.

Optional Feature:
- Macro HAZARD_PERF_CNT_EN.
- Defined:
  - stall_cycles_o increments in every cycle with pc_write_o=0 and rst_i low.
  - flush_count_o increments on every if_flush_o cycle.
  - Both counters saturate at all-ones and reset to 0.
- Undefined: both ports are tied to 0 and no counter flops are inferred.

Decomposition:
- Package pipe_ctrl_pkg holds:
  - State enum (RUN=2'd0, MEM_WAIT=2'd1, MDU_WAIT=2'd2).
  - RA_W default.
  - Control-vector field positions shared with the stage registers.
- One sub-module: hazard_perf_cnt, a saturating PERF_W counter with async reset, instantiated twice under the macro.

Test Plan:
- Reset then release, with ex_memread=1, ex_rt=5, id_rs=5 → the cycle after release: pc_write=0, ifid_write=0, idex_bubble=1 for exactly 1 cycle; defaults on the next cycle.
- ex_memread=1, ex_rt=0, id_rs=0 → no stall; all writes=1.
- id_branch_taken=1 alone → if_flush=1, pc_write=1 for 1 cycle. The same input together with a load-use hit → flush=0, stall wins.
- id_mdu_op=1 with MDU_LAT=4 → mdu_start pulses in cycle 0; pc_write=0 in cycles 1–3; pc_write=1 in cycle 4.
- mem_req=1, mem_ack=0 for 3 cycles then ack → all writes=0, memwb_bubble=1 for 3 cycles; advance on the ack cycle. Issue an MDU op with MDU_LAT=4 one cycle before the freeze → state is RUN after the ack (mdu_cnt expired during the freeze).
- HAZARD_PERF_CNT_EN defined: 1 load-use stall, 3-cycle freeze, 2 flushes → stall_cycles_o=4, flush_count_o=2. rst_i asserted mid-freeze → all outputs take reset values immediately, state=RUN.
